model_matrix_inverse: RTL and testbench

MODEL_MATRIX_INVERSE -- requirements
Module: model_matrix_inverse

---
 rtl/model_matrix_inverse_pkg.sv | 21 ++
 rtl/model_scalar_fixed_divider.sv | 74 +++++++
 rtl/model_matrix_inverse.sv | 249 ++++++++++++++++++++++++
 tb/tb_model_matrix_inverse.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/model_matrix_inverse_pkg.sv
// Shared state encoding and fixed-point helper for the Gauss-Jordan matrix inverter.
package model_matrix_inverse_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SEARCH,
        SWAP,
        DIVIDE,
        NORMALIZE,
        ELIMINATE,
        OUTPUT,
        FINISH
    } state_t;

    // Fixed-point 1.0, i.e. 1 << fraction.
    function automatic logic [63:0] fixed_one(input int fraction);
        return 64'd1 << fraction;
    endfunction

endpackage

// File: rtl/model_scalar_fixed_divider.sv
// Iterative restoring divider: quotient = (dividend << FRACTION) / divisor, truncated toward zero.
module model_scalar_fixed_divider #(
    parameter int DATA_SIZE = 32,
    parameter int FRACTION  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] dividend,
    input  logic [DATA_SIZE-1:0] divisor,
    output logic [DATA_SIZE-1:0] quotient,
    output logic                 ready
);

    localparam int W  = DATA_SIZE;
    localparam int CW = $clog2(W + 1);

    logic          busy;
    logic          negate;
    logic [CW-1:0] count;
    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvs;
    logic [W-1:0]  mag_a;
    logic [W-1:0]  mag_b;
    logic [2*W-1:0] numer;
    logic [W:0]    rem_shift;

    assign mag_a     = dividend[W-1] ? -dividend : dividend;
    assign mag_b     = divisor[W-1] ? -divisor : divisor;
    assign numer     = {{W{1'b0}}, mag_a} << FRACTION;
    assign rem_shift = {rem, quo[W-1]};

    // The upper half of the shifted numerator seeds the remainder; the quotient
    // only fits when that seed is below the divisor magnitude (otherwise it wraps).
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            negate   <= 1'b0;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            quotient <= '0;
            ready    <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy   <= 1'b1;
                    count  <= '0;
                    rem    <= numer[2*W-1:W];
                    quo    <= numer[W-1:0];
                    dvs    <= mag_b;
                    negate <= dividend[W-1] ^ divisor[W-1];
                end
            end else if (count != CW'(W)) begin
                if (rem_shift >= {1'b0, dvs}) begin
                    rem <= W'(rem_shift - {1'b0, dvs});
                    quo <= {quo[W-2:0], 1'b1};
                end else begin
                    rem <= rem_shift[W-1:0];
                    quo <= {quo[W-2:0], 1'b0};
                end
                count <= count + CW'(1);
            end else begin
                quotient <= negate ? -quo : quo;
                ready    <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/model_matrix_inverse.sv
// Fixed-point N x N matrix inverter: Gauss-Jordan on [A | I] with one shared multiplier.
module model_matrix_inverse
    import model_matrix_inverse_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int FRACTION     = 16,
    parameter int SIZE_MAX     = 4,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] SIZE_IN,
    input  logic                 DATA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic                 DATA_OUT_I_ENABLE,
    output logic                 DATA_OUT_J_ENABLE,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 SINGULAR,
    output logic                 READY,
    output state_t               fsm_state
);

    localparam int W  = DATA_SIZE;
    localparam int RW = (SIZE_MAX > 1) ? $clog2(SIZE_MAX) : 1;
    localparam int CW = $clog2(2 * SIZE_MAX);
    // CONTROL_SIZE only exists for interface compatibility with the family.
    localparam int IW = $clog2(2 * SIZE_MAX + 1) + 0 * CONTROL_SIZE;
    localparam logic [W-1:0] ONE = W'(fixed_one(FRACTION));

    state_t state;
    logic [IW-1:0] n, k, row, col, swap_row;
    logic [W-1:0]  recip, factor;
    logic [W-1:0]  mat [SIZE_MAX][2*SIZE_MAX];

    logic          div_start, div_ready;
    logic [W-1:0]  div_quotient;
    logic [W-1:0]  pivot, mul_a, mul_b, scaled;
    logic [2*W-1:0] prod;
    logic          unused_prod_bits;
    logic          size_ok, swap_found, last_k;
    logic [IW-1:0] size_n, swap_idx, last_col, first_row, row_inc, next_row;

    function automatic logic [RW-1:0] ri(input logic [IW-1:0] x);
        return x[RW-1:0];
    endfunction

    function automatic logic [CW-1:0] ci(input logic [IW-1:0] x);
        return x[CW-1:0];
    endfunction

    assign fsm_state = state;
    assign size_n    = SIZE_IN[IW-1:0];
    assign size_ok   = (SIZE_IN != '0) && (SIZE_IN <= W'(SIZE_MAX));
    assign pivot     = mat[ri(k)][ci(k)];
    assign last_col  = IW'({n, 1'b0} - 1'b1);
    assign last_k    = (k + IW'(1)) == n;
    assign first_row = (k == '0) ? IW'(1) : '0;
    assign row_inc   = row + IW'(1);
    assign next_row  = (row_inc == k) ? row + IW'(2) : row_inc;

    always_comb begin
        swap_found = 1'b0;
        swap_idx   = '0;
        for (int r = 0; r < SIZE_MAX; r++) begin
            if (!swap_found && IW'(r) > k && IW'(r) < n && mat[RW'(r)][ci(k)] != '0) begin
                swap_found = 1'b1;
                swap_idx   = IW'(r);
            end
        end
    end

    // The single multiplier: row k times reciprocal, or elimination factor times row k.
    always_comb begin
        mul_a = mat[ri(k)][ci(col)];
        mul_b = recip;
        if (state == ELIMINATE) begin
            mul_a = factor;
            mul_b = mat[ri(k)][ci(col)];
        end
    end

    assign prod   = {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
    assign scaled = prod[FRACTION +: W];
    assign unused_prod_bits = ^{prod[FRACTION-1:0], prod[2*W-1:FRACTION+W]};

    model_scalar_fixed_divider #(
        .DATA_SIZE(DATA_SIZE),
        .FRACTION (FRACTION)
    ) u_divider (
        .clk     (CLK),
        .rst     (RST),
        .start   (div_start),
        .dividend(ONE),
        .divisor (pivot),
        .quotient(div_quotient),
        .ready   (div_ready)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= IDLE;
            n                 <= '0;
            k                 <= '0;
            row               <= '0;
            col               <= '0;
            swap_row          <= '0;
            recip             <= '0;
            factor            <= '0;
            div_start         <= 1'b0;
            READY             <= 1'b0;
            SINGULAR          <= 1'b0;
            DATA_OUT_I_ENABLE <= 1'b0;
            DATA_OUT_J_ENABLE <= 1'b0;
            DATA_OUT          <= '0;
        end else begin
            READY             <= 1'b0;
            DATA_OUT_I_ENABLE <= 1'b0;
            DATA_OUT_J_ENABLE <= 1'b0;
            DATA_OUT          <= '0;
            div_start         <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        SINGULAR <= !size_ok;
                        if (size_ok) begin
                            n     <= size_n;
                            k     <= '0;
                            row   <= '0;
                            col   <= '0;
                            state <= LOAD;
                            for (int r = 0; r < SIZE_MAX; r++) begin
                                for (int c = 0; c < 2 * SIZE_MAX; c++) begin
                                    if (c >= int'(size_n))
                                        mat[RW'(r)][CW'(c)] <= (c - int'(size_n) == r) ? ONE : '0;
                                end
                            end
                        end else begin
                            READY <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                LOAD: begin
                    if (DATA_IN_ENABLE) begin
                        mat[ri(row)][ci(col)] <= DATA_IN;
                        if (col == n - IW'(1)) begin
                            col <= '0;
                            if (row == n - IW'(1)) begin
                                row   <= '0;
                                k     <= '0;
                                state <= SEARCH;
                            end else begin
                                row <= row + IW'(1);
                            end
                        end else begin
                            col <= col + IW'(1);
                        end
                    end
                end
                SEARCH: begin
                    if (pivot != '0) begin
                        div_start <= 1'b1;
                        state     <= DIVIDE;
                    end else if (swap_found) begin
                        swap_row <= swap_idx;
                        state    <= SWAP;
                    end else begin
                        SINGULAR <= 1'b1;
                        READY    <= 1'b1;
                        state    <= FINISH;
                    end
                end
                SWAP: begin
                    for (int c = 0; c < 2 * SIZE_MAX; c++) begin
                        mat[ri(k)][CW'(c)]        <= mat[ri(swap_row)][CW'(c)];
                        mat[ri(swap_row)][CW'(c)] <= mat[ri(k)][CW'(c)];
                    end
                    div_start <= 1'b1;
                    state     <= DIVIDE;
                end
                DIVIDE: begin
                    if (div_ready) begin
                        recip <= div_quotient;
                        col   <= '0;
                        state <= NORMALIZE;
                    end
                end
                NORMALIZE: begin
                    mat[ri(k)][ci(col)] <= scaled;
                    if (col == last_col) begin
                        col <= '0;
                        if (n != IW'(1)) begin
                            // Factor of the first row to clear is untouched by normalisation.
                            row    <= first_row;
                            factor <= mat[ri(first_row)][ci(k)];
                            state  <= ELIMINATE;
                        end else if (last_k) begin
                            row   <= '0;
                            state <= OUTPUT;
                        end else begin
                            k     <= k + IW'(1);
                            state <= SEARCH;
                        end
                    end else begin
                        col <= col + IW'(1);
                    end
                end
                ELIMINATE: begin
                    mat[ri(row)][ci(col)] <= mat[ri(row)][ci(col)] - scaled;
                    if (col == last_col) begin
                        col <= '0;
                        if (next_row < n) begin
                            row    <= next_row;
                            factor <= mat[ri(next_row)][ci(k)];
                        end else if (last_k) begin
                            row   <= '0;
                            state <= OUTPUT;
                        end else begin
                            k     <= k + IW'(1);
                            state <= SEARCH;
                        end
                    end else begin
                        col <= col + IW'(1);
                    end
                end
                OUTPUT: begin
                    if (row == n) begin
                        READY <= 1'b1;
                        state <= FINISH;
                    end else begin
                        DATA_OUT_J_ENABLE <= 1'b1;
                        DATA_OUT_I_ENABLE <= (col == '0);
                        DATA_OUT          <= mat[ri(row)][ci(n + col)];
                        if (col == n - IW'(1)) begin
                            col <= '0;
                            row <= row + IW'(1);
                        end else begin
                            col <= col + IW'(1);
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_model_matrix_inverse.sv
// Directed bench for model_matrix_inverse with hand-computed inverses.
module tb_model_matrix_inverse;
    import model_matrix_inverse_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] size_in = '0;
    logic         data_in_enable = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         i_en, j_en, singular, ready;
    logic [W-1:0] data_out;
    state_t       fsm_state;

    int total = 0;
    int passed = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_q[$];
    logic         i_q[$];
    logic         got_ready, sing_at_ready, injected;
    int           first_out_cycle, cycles, idle_nonzero;

    always #5 clk = ~clk;

    model_matrix_inverse #(
        .DATA_SIZE(32), .FRACTION(16), .SIZE_MAX(4), .CONTROL_SIZE(4)
    ) dut (
        .CLK(clk), .RST(rst), .START(start), .SIZE_IN(size_in),
        .DATA_IN_ENABLE(data_in_enable), .DATA_IN(data_in),
        .DATA_OUT_I_ENABLE(i_en), .DATA_OUT_J_ENABLE(j_en), .DATA_OUT(data_out),
        .SINGULAR(singular), .READY(ready), .fsm_state(fsm_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic start_op(input logic [W-1:0] n);
        start   = 1'b1;
        size_in = n;
        step();
        start   = 1'b0;
        size_in = '0;
    endtask

    task automatic send(input logic [W-1:0] v, input bit gap);
        data_in_enable = 1'b1;
        data_in        = v;
        step();
        data_in_enable = 1'b0;
        data_in        = 32'hDEAD_BEEF;
        if (gap) step();
    endtask

    task automatic send4(input logic [W-1:0] a, b, c, d);
        send(a, 1'b0);
        send(b, 1'b1);
        send(c, 1'b0);
        send(d, 1'b0);
    endtask

    task automatic set_exp4(input logic [W-1:0] a, b, c, d);
        exp_q.delete();
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    // Watch outputs until READY, optionally firing a START while eliminating.
    task automatic collect(input int budget, input bit inject);
        out_q.delete();
        i_q.delete();
        got_ready       = 1'b0;
        sing_at_ready   = 1'b0;
        injected        = 1'b0;
        first_out_cycle = -1;
        idle_nonzero    = 0;
        cycles          = 0;
        for (int c = 0; c < budget; c++) begin
            cycles = c;
            if (j_en === 1'b1) begin
                out_q.push_back(data_out);
                i_q.push_back(i_en);
                if (first_out_cycle < 0) first_out_cycle = c;
            end else if (data_out !== '0 || i_en !== 1'b0) begin
                idle_nonzero++;
            end
            if (ready === 1'b1) begin
                got_ready     = 1'b1;
                sing_at_ready = singular;
                break;
            end
            if (inject && !injected && fsm_state == ELIMINATE) begin
                start    = 1'b1;
                size_in  = 32'd5;
                injected = 1'b1;
            end
            step();
            start   = 1'b0;
            size_in = '0;
        end
    endtask

    task automatic check_result(input string tag, input int n, input logic exp_sing);
        int bound;
        bound = n * (W + 4 + 2 * n + 2 * n * (n - 1) + 2);
        check({tag, "_ready_seen"}, W'(got_ready), 1);
        check({tag, "_singular"}, W'(sing_at_ready), W'(exp_sing));
        check({tag, "_out_count"}, W'(out_q.size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_out%0d", tag, i),
                  (i < out_q.size()) ? out_q[i] : 'x, exp_q[i]);
            check($sformatf("%s_i_en%0d", tag, i),
                  (i < i_q.size()) ? W'(i_q[i]) : 'x, W'((i % n) == 0));
        end
        check({tag, "_idle_out_zero"}, W'(idle_nonzero), 0);
        if (!exp_sing)
            check({tag, "_latency"}, W'(first_out_cycle >= 0 && first_out_cycle <= bound), 1);
        step();
        check({tag, "_ready_one_cycle"}, W'(ready), 0);
        check({tag, "_singular_held"}, W'(singular), W'(exp_sing));
    endtask

    initial begin
        step();
        step();
        check("rst_ready", W'(ready), 0);
        check("rst_singular", W'(singular), 0);
        check("rst_i_en", W'(i_en), 0);
        check("rst_j_en", W'(j_en), 0);
        check("rst_data_out", data_out, 0);
        check("rst_state", W'(fsm_state), W'(IDLE));
        rst = 1'b0;
        step();

        // Stray data outside LOAD must be ignored.
        send(32'h1234_5678, 1'b0);

        start_op(2);
        send4(32'h10000, 0, 0, 32'h10000);
        collect(400, 1'b0);
        set_exp4(32'h10000, 0, 0, 32'h10000);
        check_result("identity", 2, 1'b0);

        start_op(2);
        send4(32'h20000, 0, 0, 32'h40000);
        collect(400, 1'b0);
        set_exp4(32'h8000, 0, 0, 32'h4000);
        check_result("diag", 2, 1'b0);

        start_op(2);
        send4(0, 32'h10000, 32'h10000, 0);
        collect(400, 1'b0);
        set_exp4(0, 32'h10000, 32'h10000, 0);
        check_result("swap", 2, 1'b0);

        // [[1,2],[3,4]]^-1 = [[-2,1],[1.5,-0.5]]; a START during ELIMINATE is ignored.
        start_op(2);
        send4(32'h10000, 32'h20000, 32'h30000, 32'h40000);
        collect(400, 1'b1);
        check("general_start_injected", W'(injected), 1);
        set_exp4(32'hFFFE_0000, 32'h10000, 32'h18000, 32'hFFFF_8000);
        check_result("general", 2, 1'b0);

        start_op(2);
        send4(32'h10000, 32'h20000, 32'h20000, 32'h40000);
        collect(400, 1'b0);
        exp_q.delete();
        check_result("singular", 2, 1'b1);

        start_op(5);
        collect(10, 1'b0);
        check("size5_ready_next_cycle", W'(cycles), 0);
        exp_q.delete();
        check_result("size5", 1, 1'b1);

        start_op(0);
        collect(10, 1'b0);
        check("size0_ready_next_cycle", W'(cycles), 0);
        exp_q.delete();
        check_result("size0", 1, 1'b1);

        // Abort mid-load, then a clean 1x1 run.
        start_op(2);
        send(32'h11111, 1'b0);
        send(32'h22222, 1'b0);
        rst = 1'b1;
        step();
        check("midrst_state", W'(fsm_state), W'(IDLE));
        check("midrst_singular", W'(singular), 0);
        check("midrst_ready", W'(ready), 0);
        rst = 1'b0;
        step();
        start_op(1);
        send(32'h40000, 1'b0);
        collect(200, 1'b0);
        exp_q.delete();
        exp_q.push_back(32'h4000);
        check_result("after_rst", 1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
